// File: rtl/r4mdc_pkg.sv
// Shared types and constants for the radix-4 MDC FFT input stage.
// Optional frame alignment input is enabled by defining COMMUTATOR_IN_SYNC_EN.
package r4mdc_pkg;

    localparam int WL_DEFAULT = 16;

    typedef struct packed {
        logic [WL_DEFAULT-1:0] re;
        logic [WL_DEFAULT-1:0] im;
    } cplx_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Ceiling log2, usable in constant expressions for address widths.
    function automatic int log2c(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/r4mdc_quarter_buffer.sv
// One quarter-frame of sample storage: synchronous write, combinational read.
// Optional frame alignment input is enabled by defining COMMUTATOR_IN_SYNC_EN.
module r4mdc_quarter_buffer #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/r4mdc_input_commutator.sv
// Input commutator of the radix-4 MDC FFT: buffers quarters 0..2 and emits aligned quadruples in quarter 3.
// Optional frame alignment input is enabled by defining COMMUTATOR_IN_SYNC_EN.
module r4mdc_input_commutator
    import r4mdc_pkg::*;
#(
    parameter int WL = WL_DEFAULT,
    parameter int N  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [WL-1:0] in_r,
    input  logic [WL-1:0] in_i,
    input  logic          in_valid,
`ifdef COMMUTATOR_IN_SYNC_EN
    input  logic          frame_sync,
`endif
    output logic [WL-1:0] out1_r,
    output logic [WL-1:0] out1_i,
    output logic [WL-1:0] out2_r,
    output logic [WL-1:0] out2_i,
    output logic [WL-1:0] out3_r,
    output logic [WL-1:0] out3_i,
    output logic [WL-1:0] out4_r,
    output logic [WL-1:0] out4_i,
    output logic          output_valid,
    output logic          out_last
);

    localparam int CW    = log2c(N);
    localparam int AW    = (CW > 2) ? CW - 2 : 1;
    localparam int DEPTH = N / 4;
    localparam int DW    = 2 * WL;

    logic [CW-1:0] cnt_q, cnt_d, cntEff;
    logic [1:0]    quarter;
    logic [AW-1:0] addr;
    logic [DW-1:0] inWord;
    logic [DW-1:0] rdData [3];

    logic [DW-1:0] lane1_q, lane2_q, lane3_q, lane4_q;
    logic          valid_q, last_q;

    // A sync pulse re-bases the current sample to index 0 before it is stored.
    always_comb begin
        cntEff = cnt_q;
`ifdef COMMUTATOR_IN_SYNC_EN
        if (in_valid && frame_sync) begin
            cntEff = '0;
        end
`endif
        cnt_d = in_valid ? cntEff + CW'(1) : cnt_q;
    end

    assign quarter = cntEff[CW-1:CW-2];
    assign inWord  = {in_r, in_i};

    generate
        if (CW > 2) begin : g_addr
            assign addr = cntEff[AW-1:0];
        end else begin : g_addr_single
            assign addr = '0;
        end
    endgenerate

    for (genvar b = 0; b < 3; b++) begin : g_buf
        r4mdc_quarter_buffer #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_buf (
            .clk     (clk),
            .we_i    (in_valid && (quarter == 2'(b))),
            .waddr_i (addr),
            .wdata_i (inWord),
            .raddr_i (addr),
            .rdata_o (rdData[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            lane1_q <= '0;
            lane2_q <= '0;
            lane3_q <= '0;
            lane4_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (in_valid && (quarter == Q3)) begin
                lane1_q <= rdData[0];
                lane2_q <= rdData[1];
                lane3_q <= rdData[2];
                lane4_q <= inWord;
                valid_q <= 1'b1;
                last_q  <= (addr == AW'(DEPTH - 1));
            end else begin
                lane1_q <= '0;
                lane2_q <= '0;
                lane3_q <= '0;
                lane4_q <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign out1_r       = lane1_q[DW-1:WL];
    assign out1_i       = lane1_q[WL-1:0];
    assign out2_r       = lane2_q[DW-1:WL];
    assign out2_i       = lane2_q[WL-1:0];
    assign out3_r       = lane3_q[DW-1:WL];
    assign out3_i       = lane3_q[WL-1:0];
    assign out4_r       = lane4_q[DW-1:WL];
    assign out4_i       = lane4_q[WL-1:0];
    assign output_valid = valid_q;
    assign out_last     = last_q;

endmodule

// File: tb/tb_r4mdc_input_commutator.sv
// Self-checking bench for r4mdc_input_commutator (N=16) against a frame-indexed reference model.
// Sync-input scenarios are exercised when COMMUTATOR_IN_SYNC_EN is defined.
module tb_r4mdc_input_commutator;
    import r4mdc_pkg::*;

    localparam int WL = 16;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WL-1:0] in_r = '0;
    logic [WL-1:0] in_i = '0;
    logic          in_valid = 1'b0;
    logic          frame_sync = 1'b0;
    logic [WL-1:0] out1_r, out1_i, out2_r, out2_i, out3_r, out3_i, out4_r, out4_i;
    logic          output_valid, out_last;

    int testsRun = 0;
    int testsFailed = 0;
    int cycle = 0;

    typedef struct {
        logic [WL-1:0] o1r, o1i, o2r, o2i, o3r, o3i, o4r, o4i;
        logic          last;
        int            cyc;
    } quad_t;

    quad_t capQ[$];

    r4mdc_input_commutator #(.WL(WL), .N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_r         (in_r),
        .in_i         (in_i),
        .in_valid     (in_valid),
`ifdef COMMUTATOR_IN_SYNC_EN
        .frame_sync   (frame_sync),
`endif
        .out1_r       (out1_r),
        .out1_i       (out1_i),
        .out2_r       (out2_r),
        .out2_i       (out2_i),
        .out3_r       (out3_r),
        .out3_i       (out3_i),
        .out4_r       (out4_r),
        .out4_i       (out4_i),
        .output_valid (output_valid),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    // Reference model: remembers every sample of the current frame by its frame index.
    cplx_t frame [N];
    int    idx = 0;
    cplx_t expLane [4];
    logic  expValid = 1'b0;
    logic  expLast = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        cplx_t s;
        if (!rst_n) begin
            idx = 0;
            expValid = 1'b0;
            expLast = 1'b0;
            for (int k = 0; k < 4; k++) expLane[k] = '0;
        end else begin
            expValid = 1'b0;
            expLast = 1'b0;
            for (int k = 0; k < 4; k++) expLane[k] = '0;
            if (in_valid) begin
`ifdef COMMUTATOR_IN_SYNC_EN
                if (frame_sync) idx = 0;
`endif
                s.re = in_r;
                s.im = in_i;
                frame[idx] = s;
                if (idx >= 3 * N / 4) begin
                    expValid = 1'b1;
                    expLast = (idx == N - 1);
                    expLane[0] = frame[idx - 3 * N / 4];
                    expLane[1] = frame[idx - N / 2];
                    expLane[2] = frame[idx - N / 4];
                    expLane[3] = s;
                end
                idx = (idx + 1) % N;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Per-cycle comparison of every output against the model, plus capture of valid quadruples.
    always @(negedge clk) begin
        logic [32*8+1:0] act, exp;
        quad_t q;
        cycle++;
        act = {output_valid, out_last, out1_r, out1_i, out2_r, out2_i, out3_r, out3_i, out4_r, out4_i};
        exp = {expValid, expLast, expLane[0].re, expLane[0].im, expLane[1].re, expLane[1].im,
               expLane[2].re, expLane[2].im, expLane[3].re, expLane[3].im};
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL cycleCompare: got v=%b l=%b lanes_r=%0d,%0d,%0d,%0d, expected v=%b l=%b lanes_r=%0d,%0d,%0d,%0d (cycle %0d)",
                     output_valid, out_last, out1_r, out2_r, out3_r, out4_r,
                     expValid, expLast, expLane[0].re, expLane[1].re, expLane[2].re, expLane[3].re, cycle);
        end
        if (output_valid === 1'b1) begin
            q.o1r = out1_r; q.o1i = out1_i; q.o2r = out2_r; q.o2i = out2_i;
            q.o3r = out3_r; q.o3i = out3_i; q.o4r = out4_r; q.o4i = out4_i;
            q.last = out_last;
            q.cyc = cycle;
            capQ.push_back(q);
        end
    end

    task automatic applyStimulus(input logic v, input int r, input int i, input logic s);
        @(negedge clk);
        in_valid = v;
        in_r = WL'(r);
        in_i = WL'(i);
        frame_sync = s;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) applyStimulus(1'b0, 0, 0, 1'b0);
    endtask

    task automatic sendSamples(input int first, input int count);
        for (int k = first; k < first + count; k++) applyStimulus(1'b1, k, k + 100, 1'b0);
    endtask

    // Hand-computed check of the first-frame pattern starting at capture position p with real base b.
    task automatic checkFrameLiteral(input string tag, input int p, input int b);
        if (capQ.size() < p + 4) begin
            checkOutput({tag, "_count"}, 32'(capQ.size()), 32'(p + 4));
            return;
        end
        for (int j = 0; j < 4; j++) begin
            checkOutput({tag, "_out1_r"}, 32'(capQ[p + j].o1r), 32'(b + j));
            checkOutput({tag, "_out2_r"}, 32'(capQ[p + j].o2r), 32'(b + 4 + j));
            checkOutput({tag, "_out3_r"}, 32'(capQ[p + j].o3r), 32'(b + 8 + j));
            checkOutput({tag, "_out4_r"}, 32'(capQ[p + j].o4r), 32'(b + 12 + j));
            checkOutput({tag, "_out1_i"}, 32'(capQ[p + j].o1i), 32'(b + j + 100));
            checkOutput({tag, "_out4_i"}, 32'(capQ[p + j].o4i), 32'(b + 12 + j + 100));
            checkOutput({tag, "_last"}, 32'(capQ[p + j].last), (j == 3) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int r, i, lastValid;
        idle(3);
        checkOutput("reset_valid", 32'(output_valid), 32'd0);
        checkOutput("reset_out1_r", 32'(out1_r), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        checkOutput("post_reset_valid", 32'(output_valid), 32'd0);

        // Single contiguous frame.
        capQ.delete();
        sendSamples(0, 16);
        idle(3);
        checkOutput("frame1_count", 32'(capQ.size()), 32'd4);
        checkFrameLiteral("frame1", 0, 0);

        // Two back-to-back frames with no bubble between them.
        capQ.delete();
        sendSamples(0, 32);
        idle(3);
        checkOutput("b2b_count", 32'(capQ.size()), 32'd8);
        checkFrameLiteral("b2b_f1", 0, 0);
        checkFrameLiteral("b2b_f2", 4, 16);
        if (capQ.size() == 8) checkOutput("b2b_contiguous", 32'(capQ[4].cyc - capQ[3].cyc), 32'd13);

        // Gaps after k=5 and k=13.
        capQ.delete();
        sendSamples(0, 6);
        idle(2);
        sendSamples(6, 8);
        idle(2);
        sendSamples(14, 2);
        idle(3);
        checkOutput("gap_count", 32'(capQ.size()), 32'd4);
        checkFrameLiteral("gap", 0, 0);
        if (capQ.size() == 4) checkOutput("gap_valid_drop", 32'(capQ[2].cyc - capQ[1].cyc), 32'd3);

        // Asynchronous reset mid-frame, then a fresh frame.
        capQ.delete();
        sendSamples(0, 10);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_valid", 32'(output_valid), 32'd0);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        sendSamples(0, 12);
        checkOutput("rst_no_early_valid", 32'(capQ.size()), 32'd0);
        sendSamples(12, 4);
        idle(3);
        checkFrameLiteral("rst", 0, 0);

`ifdef COMMUTATOR_IN_SYNC_EN
        // Re-alignment: sample 50 is forced to index 0.
        capQ.delete();
        sendSamples(0, 7);
        applyStimulus(1'b1, 50, 150, 1'b1);
        sendSamples(51, 15);
        idle(3);
        checkOutput("sync_count", 32'(capQ.size()), 32'd4);
        checkFrameLiteral("sync", 0, 50);
        // Sync in quarter 3 abandons the current frame and its out_last.
        capQ.delete();
        sendSamples(0, 13);
        applyStimulus(1'b1, 200, 300, 1'b1);
        idle(3);
        checkOutput("sync_abandon_count", 32'(capQ.size()), 32'd1);
        checkOutput("sync_ignored_when_idle", 32'(output_valid), 32'd0);
        applyStimulus(1'b0, 0, 0, 1'b1);
        sendSamples(1, 15);
        idle(3);
        checkOutput("sync_realigned_last", 32'(capQ.size()), 32'd5);
`endif

        // Randomised traffic with random gaps, checked cycle by cycle against the model.
        lastValid = 0;
        for (int c = 0; c < 400; c++) begin
            r = int'($urandom_range(0, 65535));
            i = int'($urandom_range(0, 65535));
`ifdef COMMUTATOR_IN_SYNC_EN
            applyStimulus($urandom_range(0, 3) != 0, r, i, $urandom_range(0, 60) == 0);
`else
            applyStimulus($urandom_range(0, 3) != 0, r, i, 1'b0);
`endif
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
